arith_unit_seq: RTL and testbench
=================================

// Module: arith_unit_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ADD/SUB arithmetic unit.
//  Executes ADD, SUB and an iterative shift-add unsigned MUL on WIDTH-bit operands.
//  Produces registered results plus Z/N/C/V flags.
//  Sits between the instruction decoder (mode 01, 3-bit OP field) and the register-file
//  writeback, using valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); MUL iterates WIDTH cycles
// PORTS
//  clock      in   1        single clock; all state on rising edge
//  reset      in   1        asynchronous, active-high; clears all state
//  in_valid   in   1        opcode/operands valid
//  in_ready   out  1        unit can accept a new operation
//  opcode     in   3        100 ADD, 101 SUB, 110 MUL, others -> NOP (result 0)
//  operand_a  in   WIDTH    operand A
//  operand_b  in   WIDTH    operand B
//  out_valid  out  1        result and flags valid
//  out_ready  in   1        consumer takes result
//  result     out  WIDTH    ADD/SUB result; MUL low half
//  result_hi  out  WIDTH    MUL high half; 0 for all other ops
//  flags      out  4        {Z,N,C,V}
// BEHAVIOUR
//  Reset (async assert, sync use): state=IDLE, in_ready=1, out_valid=0,
//   result=result_hi=0, flags=0, internal regs 0.
//  Accept when in_valid&&in_ready. Operands and opcode are captured at accept and not sampled again.
//  FSM IDLE -> {DONE | MUL}; MUL -> DONE; DONE -> IDLE.
//   IDLE: in_ready=1, out_valid=0.
//    On accept of ADD/SUB/NOP, compute into output regs and go to DONE.
//    On accept of MUL, load multiplicand, multiplier and accumulator (acc=0, count=0), go to MUL.
//   MUL: in_ready=0; one shift-add step per cycle, count increments.
//    After WIDTH steps (count==WIDTH-1 stepping), write {hi,lo} and go to DONE.
//   DONE: out_valid=1, in_ready=0; outputs held stable.
//    On out_ready go to IDLE; no new accept in the same cycle.
//  Latency from accept cycle to out_valid high:
//   ADD/SUB/NOP: 1 clock.
//   MUL: WIDTH+1 clocks.
//  Throughput: one op per 2 clocks (ADD/SUB) when out_ready is held high.
//  Arithmetic: WIDTH+1-bit internal sum.
//   ADD: C=carry out; V=signed overflow (A[msb]==B[msb] && R[msb]!=A[msb]).
//   SUB: R=A-B; C=borrow (A<B unsigned); V=(A[msb]!=B[msb] && R[msb]!=A[msb]).
//   MUL: unsigned 2*WIDTH product; C=V=(hi!=0); N=lo[msb]; Z=(product==0).
//   NOP/undefined: result=0, result_hi=0, Z=1, N=C=V=0.
//   Z and N are taken from result (low half) for ADD/SUB.
//  Backpressure: out_ready low holds out_valid, result and flags unchanged indefinitely.
//  Reset mid-MUL or in DONE: operation is discarded; outputs return to reset values
//   immediately (async); no out_valid for the aborted op.
//  in_valid while in MUL/DONE is ignored (in_ready=0); the producer must hold it.
// STRUCTURE
//  Package arith_pkg:
//   opcode_e {OP_ADD=3'b100, OP_SUB=3'b101, OP_MUL=3'b110}
//   state_e {IDLE, MUL, DONE}
//   flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0
//  Sub-module arith_mul_iter #(WIDTH):
//   inputs start, a, b; outputs busy, done (1-cycle pulse), product[2*WIDTH-1:0].
//   Owns the count and accumulator; the top FSM sequences it and registers outputs.
// TESTING (WIDTH=8 unless noted)
//  1. reset asserted mid-cycle -> out_valid=0, in_ready=1, result=0, flags=0 immediately.
//  2. ADD 0x7F+0x01, out_ready=1 -> out_valid 1 clk later; result=0x80, flags Z0 N1 C0 V1;
//     ADD 0xFF+0x01 -> 0x00, Z1 C1 V0.
//  3. SUB 0x05-0x05 -> 0x00, Z1 C0; SUB 0x03-0x05 -> 0xFE, N1 C1 V0;
//     SUB 0x80-0x01 -> 0x7F, V1.
//  4. MUL 0xFF*0xFF -> out_valid at accept+9 clks; hi=0xFE lo=0x01, C=V=1;
//     MUL 0x0F*0x11 -> hi 0x00 lo 0xFF, C=V=0, N=1.
//  5. ADD 0x10+0x20 with out_ready=0 for 5 clks -> out_valid, result=0x30 held stable,
//     in_ready=0; a second in_valid is not accepted until 1 clk after out_ready=1.
//  6. reset pulsed at MUL step 4 of 0xFF*0xFF -> no out_valid; next ADD 1+1 -> 0x02 normally;
//     opcode 3'b011 -> result 0, Z=1. Repeat test 4 with WIDTH=16: 0xFFFF*0xFFFF -> hi 0xFFFE
//     lo 0x0001, at accept+17 clks.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and constants for the sequential ADD/SUB/MUL arithmetic unit.
//   opcode_e : decoder OP field values the unit executes (anything else is a NOP)
//   state_e  : top-level sequencing states
//   FLAG_*   : bit positions inside the 4-bit {Z,N,C,V} flags vector
package arith_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b100,
      OP_SUB = 3'b101,
      OP_MUL = 3'b110
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/arith_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : load operands and begin (ignored while busy)
//   i_a, i_b     : multiplicand / multiplier, WIDTH bits
//   o_busy       : stepping in progress
//   o_done       : high during the final step; o_product is valid in that cycle
//   o_product    : 2*WIDTH-bit product, valid while o_done is high
module arith_mul_iter
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;
   logic               r_busy;
   logic [2*WIDTH-1:0] w_acc_next;

   // Accumulator after this cycle's step; on the last step this is the
   // finished product, so the caller can register it on the same edge.
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   assign o_busy    = r_busy;
   assign o_done    = r_busy && (r_count == LAST);
   assign o_product = w_acc_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_acc    <= '0;
         r_mplier <= i_b;
         r_count  <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CW'(1);
         if (r_count == LAST) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/arith_unit_seq.sv
// Handshaked ADD/SUB/MUL unit with registered result and {Z,N,C,V} flags.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_in_valid     : opcode/operands valid     o_in_ready : can accept
//   i_opcode       : 100 ADD, 101 SUB, 110 MUL, others NOP
//   i_operand_a/b  : WIDTH-bit operands, captured only at accept
//   o_out_valid    : result/flags valid         i_out_ready : consumer takes result
//   o_result       : ADD/SUB result or MUL low half
//   o_result_hi    : MUL high half, 0 otherwise
//   o_flags        : {Z,N,C,V}
module arith_unit_seq
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [2:0]       i_opcode,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_result_hi,
   output logic [3:0]       o_flags
);

   localparam int MSB = WIDTH - 1;

   state_e             r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_result_hi;
   logic [3:0]         r_flags;

   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_busy;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic [3:0]         w_flags;
   logic [WIDTH-1:0]   w_mul_hi;
   logic [WIDTH-1:0]   w_mul_lo;
   logic [3:0]         w_mul_flags;

   // The busy term can only matter if the FSM and iterator ever disagree;
   // it keeps a stray accept from being lost inside a running multiply.
   assign w_accept = r_in_ready && i_in_valid && !w_mul_busy;
   assign w_is_mul = (i_opcode == OP_MUL);

   arith_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (w_accept && w_is_mul),
      .i_a       (i_operand_a),
      .i_b       (i_operand_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Single-cycle ops straight from the input operands (used only at accept).
   // The WIDTH+1-bit subtract leaves the borrow in the top bit.
   always_comb begin
      w_sum   = '0;
      w_res   = '0;
      w_flags = '0;
      case (i_opcode)
         OP_ADD: begin
            w_sum           = {1'b0, i_operand_a} + {1'b0, i_operand_b};
            w_res           = w_sum[WIDTH-1:0];
            w_flags[FLAG_Z] = (w_res == '0);
            w_flags[FLAG_N] = w_res[MSB];
            w_flags[FLAG_C] = w_sum[WIDTH];
            w_flags[FLAG_V] = (i_operand_a[MSB] == i_operand_b[MSB]) &&
                              (w_res[MSB] != i_operand_a[MSB]);
         end
         OP_SUB: begin
            w_sum           = {1'b0, i_operand_a} - {1'b0, i_operand_b};
            w_res           = w_sum[WIDTH-1:0];
            w_flags[FLAG_Z] = (w_res == '0);
            w_flags[FLAG_N] = w_res[MSB];
            w_flags[FLAG_C] = w_sum[WIDTH];
            w_flags[FLAG_V] = (i_operand_a[MSB] != i_operand_b[MSB]) &&
                              (w_res[MSB] != i_operand_a[MSB]);
         end
         default: w_flags[FLAG_Z] = 1'b1;
      endcase
   end

   always_comb begin
      w_mul_hi            = w_product[2*WIDTH-1:WIDTH];
      w_mul_lo            = w_product[WIDTH-1:0];
      w_mul_flags         = '0;
      w_mul_flags[FLAG_Z] = (w_product == '0);
      w_mul_flags[FLAG_N] = w_mul_lo[MSB];
      w_mul_flags[FLAG_C] = (w_mul_hi != '0);
      w_mul_flags[FLAG_V] = (w_mul_hi != '0);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flags     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  if (w_is_mul) begin
                     r_state <= MUL;
                  end else begin
                     r_result    <= w_res;
                     r_result_hi <= '0;
                     r_flags     <= w_flags;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            MUL: begin
               // Last step: product is combinationally ready from the iterator.
               if (w_mul_done) begin
                  r_result    <= w_mul_lo;
                  r_result_hi <= w_mul_hi;
                  r_flags     <= w_mul_flags;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               // Outputs hold until taken; re-opening in_ready here means the
               // earliest next accept is the following edge.
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_result_hi = r_result_hi;
   assign o_flags     = r_flags;

endmodule

// File: tb/tb_arith_unit_seq.sv
module tb_arith_unit_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  opcode;
   logic [7:0]  opa, opb, result, result_hi;
   logic [3:0]  flags;

   // WIDTH=16 instance
   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [2:0]  opcode16;
   logic [15:0] opa16, opb16, result16, result_hi16;
   logic [3:0]  flags16;

   int n_pass = 0;
   int n_tot  = 0;

   arith_unit_seq #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_opcode(opcode),
      .i_operand_a(opa), .i_operand_b(opb),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_result(result), .o_result_hi(result_hi), .o_flags(flags)
   );

   arith_unit_seq #(.WIDTH(16)) dut16 (
      .i_clk(clk), .i_rst(rst),
      .i_in_valid(in_valid16), .o_in_ready(in_ready16), .i_opcode(opcode16),
      .i_operand_a(opa16), .i_operand_b(opb16),
      .o_out_valid(out_valid16), .i_out_ready(out_ready16),
      .o_result(result16), .o_result_hi(result_hi16), .o_flags(flags16)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference: plain integer arithmetic on the 8-bit rules.
   function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [7:0] hi, output logic [3:0] f);
      int ua, ub, sa, sb, full, s;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      r = 8'h00; hi = 8'h00; f = 4'b1000;
      if (op == 3'b100) begin
         full = ua + ub; r = full[7:0]; s = sa + sb;
         f = {r == 8'h00, r[7], full > 255, (s > 127) || (s < -128)};
      end else if (op == 3'b101) begin
         full = ua - ub; r = full[7:0]; s = sa - sb;
         f = {r == 8'h00, r[7], ua < ub, (s > 127) || (s < -128)};
      end else if (op == 3'b110) begin
         full = ua * ub; r = full[7:0]; hi = full[15:8];
         f = {full == 0, r[7], hi != 8'h00, hi != 8'h00};
      end
   endfunction

   // Issue one op, measure clocks from accept to out_valid, optionally stall the
   // consumer, then drain so the unit is back in idle on return.
   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int stall, output logic [7:0] r, output logic [7:0] hi,
                         output logic [3:0] f, output int lat);
      int w;
      @(negedge clk);
      in_valid = 1'b1; opcode = op; opa = a; opb = b; out_ready = (stall == 0);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) chk("accept_wait", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; opcode = ~op; opa = ~a; opb = ~b;   // must not be resampled
      lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      r = result; hi = result_hi; f = flags;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_hold", {result_hi, result, flags}, {hi, r, f});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b, res, hi;
      logic [3:0] fl;
      int         lat;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [7:0] r, hi, er, ehi;
      logic [3:0] f, ef;
      int lat, seen;
      logic [2:0] rop;
      logic [7:0] ra, rb;
      int rstall;

      vecs[0] = '{3'b100, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 1};
      vecs[1] = '{3'b100, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010, 1};
      vecs[2] = '{3'b101, 8'h05, 8'h05, 8'h00, 8'h00, 4'b1000, 1};
      vecs[3] = '{3'b101, 8'h03, 8'h05, 8'hFE, 8'h00, 4'b0110, 1};
      vecs[4] = '{3'b101, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 1};
      vecs[5] = '{3'b110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0011, 9};
      vecs[6] = '{3'b110, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0100, 9};
      vecs[7] = '{3'b011, 8'h12, 8'h34, 8'h00, 8'h00, 4'b1000, 1};
      vecs[8] = '{3'b111, 8'hAA, 8'h55, 8'h00, 8'h00, 4'b1000, 1};
      vecs[9] = '{3'b110, 8'h00, 8'hC3, 8'h00, 8'h00, 4'b1000, 9};

      in_valid = 0; opcode = 0; opa = 0; opb = 0; out_ready = 1;
      in_valid16 = 0; opcode16 = 0; opa16 = 0; opb16 = 0; out_ready16 = 1;

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", {result_hi, result}, 16'h0);
      chk("rst_flags", flags, 4'h0);
      chk("rst16_state", {in_ready16, out_valid16, result16, flags16}, {1'b1, 1'b0, 16'h0, 4'h0});
      @(negedge clk); rst = 1'b0;

      // Async reset mid-cycle while holding a finished result
      @(negedge clk);
      in_valid = 1; opcode = 3'b100; opa = 8'h03; opb = 8'h04; out_ready = 0;
      @(posedge clk); #1; in_valid = 0;
      chk("t1_pre_valid", out_valid, 1);
      chk("t1_pre_result", result, 8'h07);
      #2 rst = 1'b1;
      #1;
      chk("t1_valid", out_valid, 0);
      chk("t1_in_ready", in_ready, 1);
      chk("t1_result", result, 8'h00);
      chk("t1_flags", flags, 4'h0);
      @(negedge clk); rst = 1'b0; out_ready = 1;

      // Table vectors
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, hi, f, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("vec%0d_flags", i), f, vecs[i].fl);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      // Backpressure: result held, second request waits until a clock after out_ready
      @(negedge clk);
      in_valid = 1; opcode = 3'b100; opa = 8'h10; opb = 8'h20; out_ready = 0;
      @(posedge clk); #1;
      opa = 8'h01; opb = 8'h02;
      chk("t5_valid", out_valid, 1);
      chk("t5_result", result, 8'h30);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", out_valid, 1);
         chk("t5_hold_result", {result, flags}, {8'h30, 4'h0});
         chk("t5_in_ready_low", in_ready, 0);
      end
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1;
      chk("t5_release_valid", out_valid, 0);
      chk("t5_release_in_ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 0;
      chk("t5_second_valid", out_valid, 1);
      chk("t5_second_result", result, 8'h03);
      @(posedge clk); #1;

      // Reset during a multiply aborts it
      @(negedge clk);
      in_valid = 1; opcode = 3'b110; opa = 8'hFF; opb = 8'hFF; out_ready = 1;
      @(posedge clk); #1; in_valid = 0;
      repeat (4) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_result", {result_hi, result, flags}, 20'h0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (out_valid) seen++; end
      chk("t6_no_valid", seen, 0);
      run_op(3'b100, 8'h01, 8'h01, 0, r, hi, f, lat);
      chk("t6_add_result", r, 8'h02);
      chk("t6_add_flags", f, 4'h0);
      run_op(3'b011, 8'h5A, 8'h11, 0, r, hi, f, lat);
      chk("t6_nop_result", {hi, r}, 16'h0);
      chk("t6_nop_flags", f, 4'b1000);

      // Randomized against the reference
      for (int i = 0; i < 150; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = 8'($urandom); rb = 8'($urandom);
         rstall = int'($urandom_range(0, 2));
         model(rop, ra, rb, er, ehi, ef);
         run_op(rop, ra, rb, rstall, r, hi, f, lat);
         chk($sformatf("rnd%0d_op%0b_%02h_%02h_res", i, rop, ra, rb), r, er);
         chk($sformatf("rnd%0d_hi", i), hi, ehi);
         chk($sformatf("rnd%0d_flags", i), f, ef);
         chk($sformatf("rnd%0d_latency", i), lat, (rop == 3'b110) ? 9 : 1);
      end

      // WIDTH=16 multiply
      @(negedge clk);
      in_valid16 = 1; opcode16 = 3'b110; opa16 = 16'hFFFF; opb16 = 16'hFFFF; out_ready16 = 1;
      @(posedge clk); #1;
      in_valid16 = 0; opa16 = 16'h0; opb16 = 16'h0;
      lat = 1;
      while (!out_valid16 && lat < 60) begin @(posedge clk); #1; lat++; end
      chk("w16_latency", lat, 17);
      chk("w16_hi", result_hi16, 16'hFFFE);
      chk("w16_lo", result16, 16'h0001);
      chk("w16_flags", flags16, 4'b0011);
      @(posedge clk); #1;
      chk("w16_drain", out_valid16, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
